// File: rtl/seg_scan_decoder.sv
// Passive decoder for a multiplexed active-low 7-segment bus: qualifies stable digit dwells and emits one frame per scan.
// Optional macro SEG_SCAN_HEX_DECODE_EN adds the A..F glyphs (values 10..15).
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    err,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  // Returns {known, blank, value}.
  function automatic logic [5:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: return {2'b10, 4'd0};
      7'b1001111: return {2'b10, 4'd1};
      7'b0010010: return {2'b10, 4'd2};
      7'b0000110: return {2'b10, 4'd3};
      7'b1001100: return {2'b10, 4'd4};
      7'b0100100: return {2'b10, 4'd5};
      7'b0100000: return {2'b10, 4'd6};
      7'b0001111: return {2'b10, 4'd7};
      7'b0000000: return {2'b10, 4'd8};
      7'b0000100: return {2'b10, 4'd9};
      7'b1111111: return {2'b11, 4'd0};
`ifdef SEG_SCAN_HEX_DECODE_EN
      7'b0001000: return {2'b10, 4'd10};
      7'b1100000: return {2'b10, 4'd11};
      7'b0110001: return {2'b10, 4'd12};
      7'b1000010: return {2'b10, 4'd13};
      7'b0110000: return {2'b10, 4'd14};
      7'b0111000: return {2'b10, 4'd15};
`endif
      default:    return 6'b000000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] f_cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  logic [6:0]              r_seg_p0, r_seg_p1, r_seg_p2;
  logic [NUM_DIGITS-1:0]   r_an_p0, r_an_p1, r_an_p2;
  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_vals;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_marks;

  logic [NUM_DIGITS-1:0]   w_an_act;
  logic                    w_slot;
  logic                    w_same;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_capture;
  logic [5:0]              w_dec;
  logic                    w_hit;
  logic [4*NUM_DIGITS-1:0] w_vals_nx;
  logic [NUM_DIGITS-1:0]   w_blank_nx;
  logic [NUM_DIGITS-1:0]   w_marks_nx;
  logic                    w_complete;

  always_comb begin
    w_an_act   = ~r_an_p1;
    w_slot     = (w_an_act != '0) && ((w_an_act & (w_an_act - NUM_DIGITS'(1))) == '0);
    w_same     = (r_seg_p1 == r_seg_p2) && (r_an_p1 == r_an_p2);
    w_cnt_inc  = f_cnt_inc(r_cnt);
    w_capture  = w_slot && (r_state == TRACK) && w_same && (w_cnt_inc == CNT_MAX);
    w_dec      = f_decode(r_seg_p1);
    w_hit      = w_capture && w_dec[5];
    w_vals_nx  = r_vals;
    w_blank_nx = r_blank;
    w_marks_nx = r_marks;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_hit && w_an_act[i]) begin
        w_vals_nx[4*i +: 4] = w_dec[3:0];
        w_blank_nx[i]       = w_dec[4];
        w_marks_nx[i]       = 1'b1;
      end
    end
    // A capture landing in the completion cycle is already folded into w_*_nx.
    w_complete = &w_marks_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_p0    <= '0;
      r_seg_p1    <= '0;
      r_seg_p2    <= '0;
      r_an_p0     <= '0;
      r_an_p1     <= '0;
      r_an_p2     <= '0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_vals      <= '0;
      r_blank     <= '0;
      r_marks     <= '0;
      frame_data  <= '0;
      frame_blank <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // p0/p1: synchronizer, p2: previous synced sample for change detection
      r_seg_p0 <= seg_in;
      r_seg_p1 <= r_seg_p0;
      r_seg_p2 <= r_seg_p1;
      r_an_p0  <= an_in;
      r_an_p1  <= r_an_p0;
      r_an_p2  <= r_an_p1;

      if (!w_slot) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= TRACK;
            r_cnt   <= CNT_ONE;
          end
          TRACK: begin
            if (!w_same) begin
              r_cnt <= CNT_ONE;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == CNT_MAX) r_state <= HELD;
            end
          end
          HELD: begin
            if (!w_same) begin
              r_state <= TRACK;
              r_cnt   <= CNT_ONE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end

      if (w_capture && !w_dec[5]) err <= 1'b1;

      r_vals  <= w_vals_nx;
      r_blank <= w_blank_nx;
      r_marks <= w_complete ? '0 : w_marks_nx;

      // Output snapshot and handshake
      if (w_complete) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= w_vals_nx;
          frame_blank <= w_blank_nx;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
